tanh_pla_sched: RTL

Scheduler that shares one combinational `shift_PLA` tanh unit between `N_REQ` requesters (e.g. LSTM gate/cell paths). Requesters submit bursts (vectors) of fixed-point pre-activations. The block grants one requester per burst by round-robin and pipelines its samples through the PLA. Results return on a single tagged output stream with backpressure.

---
 rtl/tanh_pla_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/tanh_pla_sched.sv
// ============================================================================
// Module      : shift_PLA / tanh_pla_sched
// Description : Shift-only piecewise-linear tanh unit, shared between
//               N_REQ requesters by a round-robin burst scheduler with a
//               two-stage pipeline and a tagged, backpressured output stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// shift_PLA ports:
//   i_x        in   W_IN   two's complement, 5 integer bits
//   o_y        out  W_OUT  two's complement, 1 integer (sign) bit
// tanh_pla_sched ports:
//   clock      in   1              rising-edge clock
//   resetn     in   1              asynchronous active-low reset
//   req_valid  in   N_REQ          per-requester sample valid
//   req_last   in   N_REQ          last sample of the burst (with valid)
//   req_data   in   N_REQ*W_IN     requester k at [k*W_IN +: W_IN]
//   req_ready  out  N_REQ          per-requester accept (one-hot or zero)
//   out_valid  out  1              result valid
//   out_data   out  W_OUT          tanh result
//   out_id     out  ID_W           producing requester
//   out_last   out  1              last result of its burst
//   out_ready  in   1              downstream accept
//   busy       out  1              burst active or pipeline occupied
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module shift_PLA #(
  parameter int W_IN  = 12,
  parameter int W_OUT = 8
) (
  input  logic [W_IN-1:0]  i_x,
  output logic [W_OUT-1:0] o_y
);
  // Input and output share the same number of fraction bits (F).
  localparam int              c_F    = W_OUT - 1;
  localparam logic [W_IN:0]   c_HALF = (W_IN+1)'(2 ** (c_F - 1));
  localparam logic [W_IN:0]   c_ONE  = (W_IN+1)'(2 ** c_F);
  localparam logic [W_IN:0]   c_TWO  = (W_IN+1)'(2 ** (c_F + 1));

  logic [W_IN:0]  w_abs;
  logic [c_F-1:0] w_mag;

  // One extra bit so that the most negative code has a representable magnitude.
  assign w_abs = i_x[W_IN-1] ? ((W_IN+1)'(0) - {1'b1, i_x}) : {1'b0, i_x};

  // Segments: y=|x| below 0.5, |x|/2+0.25 below 1, |x|/4+0.5 below 2, then
  // saturate. The offsets fold into the leading bits, so each segment is a
  // pure bit-select with a constant prefix.
  always_comb begin
    w_mag = {c_F{1'b1}};
    if (w_abs < c_HALF)      w_mag = {1'b0, w_abs[c_F-2:0]};
    else if (w_abs < c_ONE)  w_mag = {2'b10, w_abs[c_F-2:1]};
    else if (w_abs < c_TWO)  w_mag = {2'b11, w_abs[c_F-1:2]};
  end

  assign o_y = i_x[W_IN-1] ? (W_OUT'(0) - {1'b0, w_mag}) : {1'b0, w_mag};
endmodule

module tanh_pla_sched #(
  parameter int W_IN  = 12,
  parameter int W_OUT = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_last,
  input  logic [N_REQ*W_IN-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  output logic [W_OUT-1:0]      out_data,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_gnt_id, w_win, w_cand;
  logic             w_any_req, w_adv, w_hs;
  logic             w_gnt_valid, w_gnt_last;
  logic [W_IN-1:0]  w_gnt_data;
  logic [W_IN-1:0]  w_req_word [N_REQ];

  logic             r_s1_v, r_s1_last;
  logic [W_IN-1:0]  r_s1_data;
  logic [ID_W-1:0]  r_s1_id;
  logic             r_s2_v, r_s2_last;
  logic [W_OUT-1:0] r_s2_data;
  logic [ID_W-1:0]  r_s2_id;
  logic [W_OUT-1:0] w_pla_y;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_req_word[gi] = req_data[gi*W_IN +: W_IN];
    end
  endgenerate

  assign w_any_req   = |req_valid;
  assign w_gnt_valid = req_valid[r_gnt_id];
  assign w_gnt_last  = req_last[r_gnt_id];
  assign w_gnt_data  = w_req_word[r_gnt_id];
  assign w_adv       = !r_s2_v || out_ready;
  assign w_hs        = (r_state == ST_BURST) && w_adv && w_gnt_valid;

  // Round-robin: scan offsets from farthest to nearest so the requester
  // closest after r_ptr is the one left standing; r_ptr itself is last.
  always_comb begin
    w_win  = r_ptr;
    w_cand = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_cand = ID_W'((int'(r_ptr) + i) % N_REQ);
      if (req_valid[w_cand]) w_win = w_cand;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_BURST;
      end
      ST_BURST: begin
        req_ready[r_gnt_id] = w_adv;
        if (w_hs && w_gnt_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= ID_W'(N_REQ - 1);
      r_gnt_id <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The IDLE cycle only arbitrates; no sample is taken here.
      if (r_state == ST_IDLE && w_any_req) begin
        r_gnt_id <= w_win;
        r_ptr    <= w_win;
      end
    end
  end

  shift_PLA #(
    .W_IN  (W_IN),
    .W_OUT (W_OUT)
  ) u_pla (
    .i_x (r_s1_data),
    .o_y (w_pla_y)
  );

  // Whole pipeline advances together; a stall freezes S1, S2 and the input.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_data <= '0;
      r_s1_id   <= '0;
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_data <= '0;
      r_s2_id   <= '0;
    end else if (w_adv) begin
      r_s1_v <= w_hs;
      if (w_hs) begin
        r_s1_data <= w_gnt_data;
        r_s1_id   <= r_gnt_id;
        r_s1_last <= w_gnt_last;
      end
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= w_pla_y;
        r_s2_id   <= r_s1_id;
        r_s2_last <= r_s1_last;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_data  = r_s2_data;
  assign out_id    = r_s2_id;
  assign out_last  = r_s2_last;
  assign busy      = (r_state == ST_BURST) || r_s1_v || r_s2_v;
endmodule

`default_nettype wire
